// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and helpers for the L1 instruction-cache refill path.
// Block geometry is passed in so every user agrees on the same alignment rule.
package icache_refill_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } refill_state_t;

  localparam int REP_BEAT_W = 64;

  // Clears the byte-offset bits of an address; blkBytes must be a power of two.
  function automatic logic [31:0] block_base(input logic [31:0] addr, input int unsigned blkBytes);
    logic [31:0] offMask;
    offMask = blkBytes - 1;
    return addr & ~offMask;
  endfunction

endpackage

// File: rtl/icache_refill_buf.sv
// Line buffer holding one cache block as 64-bit beats.
// Single write port driven by memory responses, combinational read for streaming.
module icache_refill_buf
  import icache_refill_ctrl_pkg::*;
#(
  parameter int Depth = 8,
  parameter int AddrW = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AddrW-1:0]      waddr,
  input  logic [REP_BEAT_W-1:0] wdata,
  input  logic [AddrW-1:0]      raddr,
  output logic [REP_BEAT_W-1:0] rdata
);

  logic [REP_BEAT_W-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/icache_refill_ctrl.sv
// Refill engine: fetches a missing I-cache block beat by beat from memory into a
// line buffer, then streams it to the cache as RepCycles back-to-back RepReady beats.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int B = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           PCF,
  input  logic                  InstrMissF,
  input  logic                  InstrCacheRepActive,
  output logic                  RepReady,
  output logic [REP_BEAT_W-1:0] RepWord,
  output logic                  MemReq,
  output logic [31:0]           MemAddr,
  input  logic                  MemValid,
  input  logic [REP_BEAT_W-1:0] MemRData,
  output logic                  RefillBusy,
  output refill_state_t         StateDbg
);

  localparam int RepCycles = B / 8;
  localparam int CntW      = $clog2(RepCycles);
  localparam logic [CntW-1:0] LastBeat = CntW'(RepCycles - 1);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  // Memory side: MemReq/MemAddr are held stable until a cycle with MemValid=1,
  // which completes that beat; MemValid while MemReq=0 is dropped. Cache side:
  // RepReady marks a valid RepWord and has no ready, so beats must be taken every cycle.

  refill_state_t state, stateNext;
  logic [31:0]           blkAddr, blkAddrNext;
  logic [CntW-1:0]       fetchCnt, fetchCntNext, fetchCntInc;
  logic [CntW-1:0]       streamCnt, streamCntNext;
  logic                  memReqNext, repReadyNext;
  logic [31:0]           memAddrNext;
  logic [REP_BEAT_W-1:0] repWordNext;
  logic                  bufWe;
  logic [REP_BEAT_W-1:0] bufRData;
  logic                  unusedRepActive;

  // The cache's acceptance flag carries no information the refill timing needs.
  assign unusedRepActive = InstrCacheRepActive;

  assign StateDbg   = state;
  assign RefillBusy = (state != IDLE);

  icache_refill_buf #(
    .Depth (RepCycles),
    .AddrW (CntW)
  ) u_buf (
    .clk   (clk),
    .we    (bufWe),
    .waddr (fetchCnt),
    .wdata (MemRData),
    .raddr (streamCnt),
    .rdata (bufRData)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      blkAddr   <= '0;
      fetchCnt  <= '0;
      streamCnt <= '0;
      MemReq    <= 1'b0;
      MemAddr   <= '0;
      RepReady  <= 1'b0;
      RepWord   <= '0;
    end else begin
      state     <= stateNext;
      blkAddr   <= blkAddrNext;
      fetchCnt  <= fetchCntNext;
      streamCnt <= streamCntNext;
      MemReq    <= memReqNext;
      MemAddr   <= memAddrNext;
      RepReady  <= repReadyNext;
      RepWord   <= repWordNext;
    end
  end

  always_comb begin
    stateNext     = state;
    blkAddrNext   = blkAddr;
    fetchCntNext  = fetchCnt;
    streamCntNext = streamCnt;
    memReqNext    = MemReq;
    memAddrNext   = MemAddr;
    repReadyNext  = RepReady;
    repWordNext   = RepWord;
    bufWe         = 1'b0;
    fetchCntInc   = fetchCnt + CntOne;

    case (state)
      IDLE: begin
        if (InstrMissF) begin
          stateNext    = FETCH;
          blkAddrNext  = block_base(PCF, B);
          fetchCntNext = '0;
          memReqNext   = 1'b1;
          memAddrNext  = block_base(PCF, B);
        end
      end

      FETCH: begin
        if (MemValid && MemReq) begin
          bufWe = 1'b1;
          if (fetchCnt == LastBeat) begin
            memReqNext    = 1'b0;
            streamCntNext = '0;
            stateNext     = STREAM;
          end else begin
            fetchCntNext = fetchCntInc;
            // Block-aligned base, so adding the beat offset never carries out.
            memAddrNext  = blkAddr + 32'({fetchCntInc, 3'b000});
          end
        end
      end

      STREAM: begin
        // streamCnt wraps to zero once the last beat is registered onto RepWord.
        if (RepReady && (streamCnt == '0)) begin
          repReadyNext = 1'b0;
          repWordNext  = '0;
          stateNext    = DONE;
        end else begin
          repReadyNext  = 1'b1;
          repWordNext   = bufRData;
          streamCntNext = streamCnt + CntOne;
        end
      end

      DONE: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Memory-side refill engine for the L1 instruction cache; it is the supplier end of the cache's RepReady/RepWord replacement interface.
- On an instruction miss it latches the missing block address and fetches the whole block from backing memory, one 64-bit beat per memory response, into a line buffer.
- It then streams the block to the cache as B/8 consecutive RepReady/RepWord beats.
- It sits between icache_l1 and the L2/memory port.

Parameters:
B, 64, block size in bytes; power of two, >=16; must match the icache_l1 B
RepCycles, B/8, derived localparam: 64-bit beats per block
CntW, $clog2(RepCycles), derived localparam: beat counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
PCF  in  32  fetch address from the cache
InstrMissF  in  1  cache miss flag for PCF
InstrCacheRepActive  in  1  cache is accepting a replacement; informational, see Behaviour
RepReady  out  1  replacement beat valid to cache
RepWord  out  64  replacement beat data; beat k = block bytes [8k+7:8k]
MemReq  out  1  read request to memory, held until MemValid
MemAddr  out  32  byte address of the requested 8-byte beat
MemValid  in  1  one-cycle pulse, read data valid
MemRData  in  64  memory read data
RefillBusy  out  1  high in any state other than IDLE

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset values: state=IDLE, beat counters=0, RepReady=0, RepWord=0, MemReq=0, MemAddr=0, RefillBusy=0. Line buffer contents are don't-care.
- IDLE:
  - If InstrMissF=1 at a clock edge, latch BlkAddr={PCF[31:log2B], zeros} and clear fetch_cnt; go to FETCH.
  - InstrMissF=0 keeps IDLE.
- FETCH:
  - MemReq=1 and MemAddr=BlkAddr+8*fetch_cnt, both registered.
  - One outstanding request at a time.
  - On an edge with MemValid=1: buf[fetch_cnt]<=MemRData and fetch_cnt++. MemAddr advances on that same edge, so the next beat's request follows with no bubble.
  - When fetch_cnt==RepCycles-1 and MemValid=1: MemReq<=0, clear stream_cnt, go to STREAM.
  - MemValid while MemReq=0 is ignored.
  - Changes on PCF or InstrMissF during FETCH are ignored; the latched block always completes.
- STREAM:
  - RepReady=1 for exactly RepCycles consecutive cycles; RepWord=buf[stream_cnt] (registered outputs).
  - After the last beat (stream_cnt==RepCycles-1), go to DONE.
  - No back-pressure: the cache must accept one beat per cycle.
  - InstrCacheRepActive is not a qualifier.
- DONE:
  - One cycle with RepReady=0 so the cache can clear InstrMissF. Then go to IDLE.
  - In IDLE the miss flag is sampled again; a second miss starts a new refill from the next cycle.
- Latency: miss edge to first RepReady = 1 + sum of memory latencies + 1 cycle.
- Address arithmetic:
  - Beat offset = fetch_cnt<<3, CntW+3 bits, zero-extended.
  - No carry out of the block field, because BlkAddr is block-aligned.
  - No wrap past 0xFFFF_FFFF is possible.
- Reset asserted in any state: next edge returns to IDLE with all outputs at reset values. An in-flight memory response arriving after reset is ignored because MemReq=0.
- MemValid simultaneous with reset: reset wins.

Decomposition:
- Shared cache package holds:
  - refill_state_t enum {IDLE, FETCH, STREAM, DONE}
  - REP_BEAT_W=64
  - Helper function block_base(addr, B)
- One sub-module: icache_refill_buf. It is a RepCycles x 64 register array with one write port (we, waddr, wdata) and one combinational read port, which keeps the FSM file small.

Test Plan:
- Basic refill, B=64, memory latency 3: PCF=0x0000_1234, InstrMissF=1 -> MemAddr sequence 0x1200,0x1208,...,0x1238 (8 beats); RepReady high exactly 8 consecutive cycles; RepWord = memory words in order; RefillBusy falls after the DONE cycle.
- Zero-bubble memory (MemValid the cycle after each MemReq edge): miss at cycle t -> first RepReady at t+1+8+1; total RefillBusy duration 18 cycles.
- PCF changed to 0x0000_8000 and InstrMissF dropped mid-FETCH -> all requests still target 0x1200 block; stream unchanged.
- Spurious MemValid=1 while IDLE with data 0xDEAD -> no state change, RepReady stays 0, buffer not written.
- Reset asserted during STREAM beat 3 -> next cycle RepReady=0, MemReq=0, RefillBusy=0; a new miss at 0x40 refills the 0x40 block cleanly.
- Back-to-back misses: InstrMissF held high through DONE -> second refill starts the cycle after IDLE is re-entered, latching the current PCF block.
